// File: rtl/add_chunk_seq.sv
// Chunked wide adder sequencer: drives one external WIDTH-bit full_adder LSB chunk first.
// Optional subtract mode is compiled in with `define ADD_SEQ_SUB_EN (adds the in_sub port).
`ifndef W_COE
`define W_COE 8
`endif

module add_chunk_seq #(
  parameter int WIDTH  = `W_COE,
  parameter int NCHUNK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*NCHUNK-1:0]   in_a,
  input  logic [WIDTH*NCHUNK-1:0]   in_b,
  input  logic                      in_cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                      in_sub,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*NCHUNK-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      busy,
  output logic [WIDTH-1:0]          fa_a,
  output logic [WIDTH-1:0]          fa_b,
  output logic                      fa_cin,
  input  logic [WIDTH-1:0]          fa_sum,
  input  logic                      fa_cout
);

  localparam int N  = WIDTH * NCHUNK;
  localparam int CW = $clog2(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            cin_q;
  logic            carry_q;
  logic            sub_q;
  logic [WIDTH-1:0] b_chunk;

`ifdef ADD_SEQ_SUB_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state == IDLE && in_valid && in_ready) begin
      sub_q <= in_sub;
    end
  end
`else
  assign sub_q = 1'b0;
`endif

  // Adder slice inputs are a pure mux of registered state, parked at zero outside RUN.
  always_comb begin
    fa_a    = '0;
    fa_b    = '0;
    fa_cin  = 1'b0;
    b_chunk = '0;
    if (state == RUN) begin
      fa_a    = a_q[int'(cnt)*WIDTH +: WIDTH];
      b_chunk = b_q[int'(cnt)*WIDTH +: WIDTH];
      fa_b    = sub_q ? ~b_chunk : b_chunk;
      if (cnt == '0) begin
        fa_cin = sub_q ? 1'b1 : cin_q;
      end else begin
        fa_cin = carry_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= in_b;
            cin_q    <= in_cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          out_sum[int'(cnt)*WIDTH +: WIDTH] <= fa_sum;
          carry_q <= fa_cout;
          if (cnt == LAST) begin
            state     <= DONE;
            out_cout  <= fa_cout;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
